counter_display_ctrl: RTL and testbench

Controller for the three up/down counters (binary, grey, one-hot) and the 8-digit seven-segment display.
- Generates the shared counter step enable from a prescaler.
- Provides run/pause and single-step control from two push-buttons.
- Time-multiplexes all eight display digits to show every counter value and the count direction at once.

---
 rtl/counter_display_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_counter_display_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_display_ctrl.sv
// ---------------------------------------------------------------------------
// counter_display_ctrl
//
// Controller for the three up/down counters (binary, grey, one-hot) and the
// 8-digit seven-segment display.
//   * Prescaler produces the shared one-cycle counter advance strobe.
//   * Two push-buttons are synchronised and debounced.
//     - pause_btn toggles RUN/PAUSE.
//     - step_btn issues a single step while paused.
//   * All eight digits are time-multiplexed:
//     - digit 0 = binary value
//     - digit 1 = grey raw value
//     - digit 2 = one-hot index ('E' if not exactly one bit is set)
//     - digits 3..6 = blank
//     - digit 7 = direction ('U' up, 'd' down)
//
// Optional feature macro: DISP_BLINK_EN
//   When defined, the anodes blink with a BLINK_DIV half-period while paused.
//   When undefined, there is no blink logic and BLINK_DIV is unused.
//
// Parameters:
//   TICK_DIV   - clk cycles between step_en pulses in RUN (>= 2)
//   SCAN_DIV   - clk cycles each digit stays lit (>= 2)
//   DEB_CYCLES - stable cycles needed to accept a button level change (>= 2)
//   BLINK_DIV  - blink half-period in PAUSE, DISP_BLINK_EN only (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   dir        in   count direction, 1 = up, 0 = down
//   pause_btn  in   raw run/pause button, asynchronous, active-high
//   step_btn   in   raw single-step button, asynchronous, active-high
//   binary     in   binary counter value [2:0]
//   grey       in   grey counter value [2:0]
//   onehot     in   one-hot counter value [7:0]
//   step_en    out  one-cycle counter advance strobe
//   paused     out  1 while in PAUSE
//   AN         out  digit anodes [7:0], active-low
//   T          out  segments {g,f,e,d,c,b,a} [6:0], active-low
// ---------------------------------------------------------------------------
module counter_display_ctrl #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dir,
  input  logic       pause_btn,
  input  logic       step_btn,
  input  logic [2:0] binary,
  input  logic [2:0] grey,
  input  logic [7:0] onehot,
  output logic       step_en,
  output logic       paused,
  output logic [7:0] AN,
  output logic [6:0] T
);

  // -------------------------------------------------------------------------
  // Local constants and types
  // -------------------------------------------------------------------------
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  // Button vector positions
  localparam int BTN_PAUSE = 0;
  localparam int BTN_STEP  = 1;

  // Segment patterns, {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  // A divisor below 2 would put the terminal count on the reset value and
  // break the one-cycle strobe behaviour. Such a build gets this
  // conspicuously named empty block in its hierarchy.
  if (TICK_DIV < 2 || SCAN_DIV < 2 || DEB_CYCLES < 2 || BLINK_DIV < 2)
  begin : g_param_out_of_range
  end

  // -------------------------------------------------------------------------
  // Button synchronisers (two flops per button)
  // -------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  assign btn_raw = {step_btn, pause_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking so sync2_q takes the previous sync1_q; blocking
      // assignments would collapse the two stages into one.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncers
  //
  // The count is the run length of cycles in which the synchronised input
  // disagrees with the accepted level. The level flips on the DEB_CYCLES-th
  // disagreeing cycle. press_q is high for the first cycle the level reads 1.
  // -------------------------------------------------------------------------
  logic [1:0]       deb_level_q;
  logic [1:0]       deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [1:0]       press_q;
  logic [1:0]       press_d;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    deb_level_d = deb_level_q;
    press_d     = '0;
    for (int b = 0; b < 2; b++) begin
      deb_cnt_d[b] = '0;
      if (sync2_q[b] != deb_level_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) begin
          deb_level_d[b] = sync2_q[b];
          press_d[b]     = sync2_q[b];  // only the 0->1 flip is an event
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level_q <= '0;
      press_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        deb_cnt_q[b] <= '0;
      end
    end else begin
      deb_level_q <= deb_level_d;
      press_q     <= press_d;
      for (int b = 0; b < 2; b++) begin
        deb_cnt_q[b] <= deb_cnt_d[b];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Run/pause FSM and prescaler
  //
  // The terminal-count strobe is decoded from the registered prescaler, so
  // a pause press that lands on the terminal count still lets that step_en
  // out. The FSM then moves to PAUSE with the prescaler cleared.
  // -------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [TICK_W-1:0] presc_q;
  logic [TICK_W-1:0] presc_d;
  logic              step_pulse_q;
  logic              step_pulse_d;
  logic              tick;

  assign tick = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    presc_d      = '0;  // cleared on any state change and held in PAUSE
    step_pulse_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (press_q[BTN_PAUSE]) begin
          state_d = ST_PAUSE;
        end else if (!tick) begin
          presc_d = presc_q + TICK_W'(1);
        end
      end
      ST_PAUSE: begin
        // A simultaneous pause press wins: resume, and the step is dropped.
        if (press_q[BTN_PAUSE]) begin
          state_d = ST_RUN;
        end else if (press_q[BTN_STEP]) begin
          step_pulse_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      presc_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign step_en = tick | step_pulse_q;
  assign paused  = (state_q == ST_PAUSE);

  // -------------------------------------------------------------------------
  // Digit content for the digit about to be lit
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_num(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  logic [2:0] oh_idx;
  logic [3:0] oh_count;
  logic       oh_valid;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [6:0] seg_sel;

  always_comb begin
    oh_idx   = '0;
    oh_count = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        oh_idx   = 3'(i);
        oh_count = oh_count + 4'd1;
      end
    end
  end

  assign oh_valid = (oh_count == 4'd1);

  always_comb begin
    case (idx_q)
      3'd0:    seg_sel = seg_num(binary);
      3'd1:    seg_sel = seg_num(grey);
      3'd2:    seg_sel = oh_valid ? seg_num(oh_idx) : SEG_E;
      3'd7:    seg_sel = dir ? SEG_U : SEG_D;
      default: seg_sel = SEG_BLANK;
    endcase
  end

  // -------------------------------------------------------------------------
  // Display scan
  //
  // idx_q names the digit lit at the next update. AN and T load in the same
  // edge, so a digit never briefly shows its neighbour's pattern.
  // -------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [SCAN_W-1:0] scan_cnt_d;
  logic [7:0]        an_q;
  logic [7:0]        an_d;
  logic [6:0]        seg_q;
  logic [6:0]        seg_d;
  logic              scan_upd;

  assign scan_upd = (scan_cnt_q == SCAN_LAST);

  always_comb begin
    scan_cnt_d = scan_upd ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    an_d       = an_q;
    seg_d      = seg_q;
    if (scan_upd) begin
      idx_d = idx_q + 3'd1;  // natural 3-bit wrap 7 -> 0
      an_d  = ~(8'd1 << idx_q);
      seg_d = seg_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign T = seg_q;

`ifdef DISP_BLINK_EN
  // -------------------------------------------------------------------------
  // Pause blink
  //
  // Only a cycle that stays in PAUSE advances the blink counter. Entering or
  // leaving PAUSE resets it with the display on.
  // -------------------------------------------------------------------------
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               blink_on_q;
  logic               blink_on_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (state_q == ST_PAUSE && state_d == ST_PAUSE) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign AN = an_q | {8{~blink_on_q}};
`else
  assign AN = an_q;
`endif

endmodule

// File: tb/tb_counter_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_display_ctrl
//
// Self-checking bench for counter_display_ctrl.
//   * Small divisors keep the run short: TICK=10, SCAN=4, DEB=4, BLINK=8.
//   * A behavioural model, advanced once per clock edge, predicts the DUT.
//     - Buttons: raw samples pass through a two-sample delay, then a
//       run-length rule decides when the accepted level flips.
//     - step_en: arithmetic on the number of edges since the last resume.
//     - Display: edge number divided by the scan period.
//   * step_en, paused, AN and T are compared on every cycle, 1 time unit
//     after the rising edge.
// ---------------------------------------------------------------------------
module tb_counter_display_ctrl;

  localparam int TICK  = 10;
  localparam int SCAN  = 4;
  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dir = 1'b0;
  logic       pause_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic [2:0] binary = '0;
  logic [2:0] grey = '0;
  logic [7:0] onehot = '0;
  logic       step_en;
  logic       paused;
  logic [7:0] AN;
  logic [6:0] T;

  counter_display_ctrl #(
    .TICK_DIV  (TICK),
    .SCAN_DIV  (SCAN),
    .DEB_CYCLES(DEB),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dir      (dir),
    .pause_btn(pause_btn),
    .step_btn (step_btn),
    .binary   (binary),
    .grey     (grey),
    .onehot   (onehot),
    .step_en  (step_en),
    .paused   (paused),
    .AN       (AN),
    .T        (T)
  );

  always #5 clk = ~clk;

  // Segment table for digits 0..7 plus letters, {g,f,e,d,c,b,a}, active-low
  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  localparam logic [6:0] L_E     = 7'b0000110;
  localparam logic [6:0] L_U     = 7'b1000001;
  localparam logic [6:0] L_D     = 7'b0100001;
  localparam logic [6:0] L_BLANK = 7'b1111111;

  // Check counters
  int passed;
  int total;

  // Model state
  int         r;           // rising edges since reset release
  bit   [1:0] dl1;         // raw button sample one edge back
  bit   [1:0] dl2;         // raw button sample two edges back
  bit   [1:0] lvl;         // accepted button levels
  bit   [1:0] press_prev;  // press detected on the previous edge
  int         run_len [2]; // consecutive disagreeing samples per button
  bit         paused_m;
  int         origin;      // edge of the last RUN/PAUSE change (or reset)
  bit         pulse_m;     // single-step strobe expected this cycle
  logic [7:0] an_m;
  logic [6:0] t_m;

  function automatic logic [6:0] digit_exp(input int idx);
    logic [6:0] s;
    s = L_BLANK;
    case (idx)
      0: s = seg_tab[binary];
      1: s = seg_tab[grey];
      2: begin
        s = L_E;
        for (int i = 0; i < 8; i++) begin
          if (onehot == (8'd1 << i)) s = seg_tab[i];
        end
      end
      7: s = dir ? L_U : L_D;
      default: s = L_BLANK;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    r          = 0;
    dl1        = '0;
    dl2        = '0;
    lvl        = '0;
    press_prev = '0;
    run_len[0] = 0;
    run_len[1] = 0;
    paused_m   = 1'b0;
    origin     = 0;
    pulse_m    = 1'b0;
    an_m       = 8'hFF;
    t_m        = 7'h7F;
  endtask

  // Called just after a rising edge, while the inputs applied before that
  // edge are still being driven.
  task automatic model_edge();
    bit [1:0] raw;
    bit       seen;
    int       idx;
    raw = {step_btn, pause_btn};
    r++;
    // Presses accepted on the previous edge act on this one.
    pulse_m = paused_m && press_prev[1] && !press_prev[0];
    if (press_prev[0]) begin
      paused_m = !paused_m;
      origin   = r;
    end
    for (int b = 0; b < 2; b++) begin
      seen          = dl2[b];
      dl2[b]        = dl1[b];
      dl1[b]        = raw[b];
      press_prev[b] = 1'b0;
      if (seen != lvl[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB) begin
          lvl[b]        = seen;
          run_len[b]    = 0;
          press_prev[b] = seen;
        end
      end else begin
        run_len[b] = 0;
      end
    end
    if (r % SCAN == 0) begin
      idx  = (r / SCAN - 1) % 8;
      an_m = ~(8'd1 << idx);
      t_m  = digit_exp(idx);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, r);
  endtask

  task automatic check_all();
    logic       exp_step;
    logic [7:0] exp_an;
    exp_step = (!paused_m && ((r - origin) % TICK == TICK - 1)) || pulse_m;
    exp_an   = an_m;
`ifdef DISP_BLINK_EN
    if (paused_m && (((r - origin) / BLINK) % 2 == 1)) exp_an = 8'hFF;
`endif
    check("step_en", {7'd0, step_en}, {7'd0, exp_step});
    check("paused", {7'd0, paused}, {7'd0, paused_m});
    check("AN", AN, exp_an);
    check("T", {1'b0, T}, {1'b0, t_m});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge();
      check_all();
    end
  endtask

  // Asserts reset mid-cycle (4 time units after a rising edge), checks the
  // outputs at once, then releases 1 time unit after a later rising edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model_reset();
    binary = 3'd5;
    grey   = 3'd6;
    onehot = 8'h08;
    dir    = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Scan pattern and free-running tick
    cyc(70);

    // One-hot error cases and top bit
    onehot = 8'h00;
    cyc(40);
    onehot = 8'h06;
    cyc(40);
    onehot = 8'h80;
    dir    = 1'b1;
    cyc(40);

    // Random counter values
    repeat (200) begin
      binary = 3'($urandom);
      grey   = 3'($urandom);
      onehot = ($urandom_range(1, 0) == 1) ? 8'(1 << $urandom_range(7, 0)) : 8'($urandom);
      dir    = 1'($urandom);
      cyc(1);
    end

    // Pause, three steps, resume, ignored step in RUN
    pause_btn = 1'b1; cyc(8);
    pause_btn = 1'b0; cyc(30);
    repeat (3) begin
      step_btn = 1'b1; cyc(6);
      step_btn = 1'b0; cyc(6);
    end
    pause_btn = 1'b1; cyc(6);
    pause_btn = 1'b0; cyc(20);
    step_btn = 1'b1; cyc(6);
    step_btn = 1'b0; cyc(20);

    // Bounce: pulses shorter than the debounce window
    repeat (4) begin
      pause_btn = 1'b1; cyc(2);
      pause_btn = 1'b0; cyc(2);
    end
    pause_btn = 1'b1; cyc(3);
    pause_btn = 1'b0; cyc(10);

    // Sweep the pause press over every prescaler phase (includes the
    // terminal-count coincidence); resume with pause+step together.
    for (int k = 0; k < TICK; k++) begin
      cyc(k);
      pause_btn = 1'b1; cyc(5);
      pause_btn = 1'b0; cyc(20);
      pause_btn = 1'b1;
      step_btn  = 1'b1; cyc(5);
      pause_btn = 1'b0;
      step_btn  = 1'b0; cyc(20);
    end

    // Long pause with steps (blink visible when enabled)
    pause_btn = 1'b1; cyc(5);
    pause_btn = 1'b0; cyc(40);
    step_btn = 1'b1; cyc(5);
    step_btn = 1'b0; cyc(30);
    pause_btn = 1'b1; cyc(5);
    pause_btn = 1'b0; cyc(20);

    // Random button activity with random counter values
    repeat (200) begin
      pause_btn = 1'($urandom);
      step_btn  = 1'($urandom);
      binary    = 3'($urandom);
      grey      = 3'($urandom);
      onehot    = 8'(1 << $urandom_range(7, 0));
      dir       = 1'($urandom);
      cyc($urandom_range(8, 1));
    end
    pause_btn = 1'b0;
    step_btn  = 1'b0;
    cyc(20);

    // Reset in the middle of a debounce, button kept pressed through it
    pause_btn = 1'b1; cyc(3);
    do_reset();
    cyc(30);
    pause_btn = 1'b0; cyc(10);

    // Reset in the middle of a scan period
    cyc(6);
    do_reset();
    cyc(50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
